s0_rs_enc: RTL and testbench

Systematic RS(255,K) encoder over GF(2^8) with 4 parity symbols (t=2). It is the transmit-side counterpart of the decoder chain (syndrome, riBM KES, Chien/Forney), and its codewords produce zero syndromes in the decoder. It accepts K message symbols on a valid/ready stream and forwards them unchanged, then appends 4 parity symbols from a 4-stage LFSR. The output is registered and is back-pressured by dout_rdy.

---
 rtl/rs_pkg.sv | 15 +
 rtl/rs_gf_cmul.sv | 20 ++
 rtl/s0_rs_enc.sv | 85 ++++++++
 tb/tb_s0_rs_enc.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: GF(2^8) field and RS(255,K) t=2 generator constants shared by the encoder.
package rs_pkg;
    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam int NPAR = 4;
    localparam logic [7:0] G0 = 8'h40;
    localparam logic [7:0] G1 = 8'h78;
    localparam logic [7:0] G2 = 8'h36;
    localparam logic [7:0] G3 = 8'h0F;

    typedef enum logic [1:0] {S_DATA = 2'b01, S_PAR = 2'b10} state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
    endfunction
endpackage

// File: rtl/rs_gf_cmul.sv
// rs_gf_cmul: multiply a GF(2^8) symbol by constant C; folds to a fixed XOR network.
module rs_gf_cmul
    import rs_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] m;

    always_comb begin
        y = 8'h00;
        m = a;
        for (int i = 0; i < 8; i++) begin
            y = y ^ (C[i] ? m : 8'h00);
            m = gf_xtime(m);
        end
    end
endmodule

// File: rtl/s0_rs_enc.sv
// s0_rs_enc: systematic RS(255,K) encoder, 4 parity symbols from an LFSR,
// registered output slot with downstream back-pressure.
module s0_rs_enc
    import rs_pkg::*;
#(
    parameter int K  = 251,
    parameter int CW = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic       din_rdy,
    output logic [7:0] dout,
    output logic       dout_vld,
    input  logic       dout_rdy,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       dout_par,
    output logic       enc_busy
);
    state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] pidx;
    logic [7:0] r0, r1, r2, r3, f, m0, m1, m2, m3;
    logic load, acc;

    assign load = !dout_vld || dout_rdy;
    // gated by rstn so the handshake reads 0 while reset is held
    assign din_rdy = rstn && state == S_DATA && load;
    assign acc = din_vld && din_rdy;
    assign f = din ^ r3;
    assign enc_busy = cnt != '0 || state == S_PAR;

    rs_gf_cmul #(.C(G0)) u_g0 (.a(f), .y(m0));
    rs_gf_cmul #(.C(G1)) u_g1 (.a(f), .y(m1));
    rs_gf_cmul #(.C(G2)) u_g2 (.a(f), .y(m2));
    rs_gf_cmul #(.C(G3)) u_g3 (.a(f), .y(m3));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_DATA;
            cnt      <= '0;
            pidx     <= 2'd0;
            {r3, r2, r1, r0} <= '0;
            dout     <= 8'h00;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            dout_par <= 1'b0;
        end else if (state == S_DATA) begin
            if (acc) begin
                dout     <= din;
                dout_vld <= 1'b1;
                dout_sop <= cnt == '0;
                dout_eop <= 1'b0;
                dout_par <= 1'b0;
                r3       <= r2 ^ m3;
                r2       <= r1 ^ m2;
                r1       <= r0 ^ m1;
                r0       <= m0;
                cnt      <= cnt + 1'b1;
                if (cnt == CW'(K - 1)) begin
                    state <= S_PAR;
                    pidx  <= 2'd0;
                end
            end else if (load) begin
                dout_vld <= 1'b0;
            end
        end else if (load) begin
            // parity drains highest-order first; zeros shifted in leave the LFSR clear
            dout     <= r3;
            dout_vld <= 1'b1;
            dout_sop <= 1'b0;
            dout_par <= 1'b1;
            dout_eop <= pidx == 2'(NPAR - 1);
            {r3, r2, r1, r0} <= {r2, r1, r0, 8'h00};
            pidx     <= pidx + 2'd1;
            if (pidx == 2'(NPAR - 1)) begin
                cnt   <= '0;
                state <= S_DATA;
            end
        end
    end
endmodule

// File: tb/tb_s0_rs_enc.sv
// tb_s0_rs_enc: randomized self-checking bench; reference model is polynomial long
// division by g(x) built from its roots, plus syndrome evaluation of each codeword.
module tb_s0_rs_enc;
    logic clk = 1'b0, rstn = 1'b0, din_vld = 1'b0, dout_rdy = 1'b0;
    logic [7:0] din = 8'h00;
    int sel = 0;

    logic rdy4, vld4, sop4, eop4, par4, busy4;
    logic rdyb, vldb, sopb, eopb, parb, busyb;
    logic rdy1, vld1, sop1, eop1, par1, busy1;
    logic [7:0] d4, db, d1;

    logic s_rdy, s_vld, s_busy;
    logic [10:0] s_beat;

    int total = 0, bad = 0;
    logic [7:0] src[$];
    logic [10:0] cap[$];
    logic [10:0] exp_q[$];
    logic [7:0] gp[5];
    int low_cnt, first_c, last_c, stall_err, stall_cnt;

    always #5 clk = ~clk;

    s0_rs_enc #(.K(4), .CW(8)) u4 (
        .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld), .din_rdy(rdy4),
        .dout(d4), .dout_vld(vld4), .dout_rdy(dout_rdy), .dout_sop(sop4),
        .dout_eop(eop4), .dout_par(par4), .enc_busy(busy4)
    );
    s0_rs_enc #(.K(251), .CW(8)) ub (
        .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld), .din_rdy(rdyb),
        .dout(db), .dout_vld(vldb), .dout_rdy(dout_rdy), .dout_sop(sopb),
        .dout_eop(eopb), .dout_par(parb), .enc_busy(busyb)
    );
    s0_rs_enc #(.K(1), .CW(8)) u1 (
        .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld), .din_rdy(rdy1),
        .dout(d1), .dout_vld(vld1), .dout_rdy(dout_rdy), .dout_sop(sop1),
        .dout_eop(eop1), .dout_par(par1), .enc_busy(busy1)
    );

    always_comb begin
        s_rdy  = rdy4;
        s_vld  = vld4;
        s_busy = busy4;
        s_beat = {sop4, eop4, par4, d4};
        if (sel == 1) begin
            s_rdy  = rdyb;
            s_vld  = vldb;
            s_busy = busyb;
            s_beat = {sopb, eopb, parb, db};
        end else if (sel == 2) begin
            s_rdy  = rdy1;
            s_vld  = vld1;
            s_busy = busy1;
            s_beat = {sop1, eop1, par1, d1};
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] apow(input int e);
        logic [7:0] r;
        r = 8'h01;
        repeat (e) r = gmul(r, 8'h02);
        return r;
    endfunction

    // g(x) = prod (x + a^i), i=0..3, highest-order coefficient first
    function automatic void build_g();
        gp = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j >= 1; j--) gp[j] = gp[j] ^ gmul(apow(i), gp[j-1]);
    endfunction

    function automatic void add_exp(input logic [7:0] m[$]);
        logic [7:0] c[$];
        logic [7:0] q;
        int n;
        n = m.size();
        c = m;
        for (int i = 0; i < 4; i++) c.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            q = c[i];
            for (int j = 0; j <= 4; j++) c[i+j] = c[i+j] ^ gmul(q, gp[j]);
        end
        for (int i = 0; i < n + 4; i++)
            exp_q.push_back({1'(i == 0), 1'(i == n + 3), 1'(i >= n), i < n ? m[i] : c[i]});
    endfunction

    function automatic logic [10:0] got(input int i);
        return i < cap.size() ? cap[i] : 11'bx;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        din_vld = 1'b0;
        dout_rdy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cap.delete();
        src.delete();
        exp_q.delete();
    endtask

    task automatic run(input int vp, input int rp, input int nbeats, input int maxc, output bit to);
        int c;
        bit stalled;
        logic [10:0] held;
        c = 0;
        stalled = 1'b0;
        held = '0;
        low_cnt = 0;
        first_c = -1;
        last_c = -1;
        stall_err = 0;
        stall_cnt = 0;
        while (cap.size() < nbeats && c < maxc) begin
            @(posedge clk);
            #1;
            din_vld = src.size() > 0 && $urandom_range(99) < vp;
            din = src.size() > 0 ? src[0] : 8'h00;
            dout_rdy = $urandom_range(99) < rp;
            @(negedge clk);
            if (stalled && s_beat !== held) stall_err++;
            stalled = s_vld && !dout_rdy;
            held = s_beat;
            if (stalled) stall_cnt++;
            if (!s_rdy) low_cnt++;
            if (din_vld && s_rdy) void'(src.pop_front());
            if (s_vld && dout_rdy) begin
                cap.push_back(s_beat);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            c++;
        end
        to = cap.size() < nbeats;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            total++;
            if ({s_rdy, s_vld, s_busy, s_beat} !== 14'd0) begin
                bad++;
                $display("FAIL reset_state dut%0d got=%h want=0", s, {s_rdy, s_vld, s_busy, s_beat});
            end
        end
        rstn = 1'b1;
        sel = 0;
        #1;
        total++;
        if ({s_rdy, s_vld} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release rdy/vld got=%b want=10", {s_rdy, s_vld});
        end
    endtask

    task automatic test_known();
        logic [31:0] tm[3] = '{32'h00000000, 32'h00000001, 32'h00000002};
        logic [31:0] tp[3] = '{32'h00000000, 32'h0F367840, 32'h1E6CF080};
        logic [7:0] m[$];
        logic [31:0] pw;
        bit to;
        for (int v = 0; v < 3; v++) begin
            do_reset();
            sel = 0;
            m.delete();
            for (int b = 0; b < 4; b++) m.push_back(tm[v][31-8*b -: 8]);
            src = m;
            add_exp(m);
            run(100, 100, 8, 100, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL known%0d timeout beats=%0d want=8", v, cap.size());
            end
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got(i) !== exp_q[i]) begin
                    bad++;
                    $display("FAIL known%0d beat%0d got=%h want=%h", v, i, got(i), exp_q[i]);
                end
            end
            pw = {got(4)[7:0], got(5)[7:0], got(6)[7:0], got(7)[7:0]};
            total++;
            if (pw !== tp[v]) begin
                bad++;
                $display("FAIL known%0d parity got=%h want=%h", v, pw, tp[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m[$];
        bit to;
        do_reset();
        sel = 0;
        for (int w = 0; w < 2; w++) begin
            m.delete();
            for (int b = 0; b < 4; b++) m.push_back(8'($urandom));
            src = {src, m};
            add_exp(m);
        end
        run(100, 100, 16, 100, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL b2b timeout beats=%0d want=16", cap.size());
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (got(i) !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b beat%0d got=%h want=%h", i, got(i), exp_q[i]);
            end
        end
        total++;
        if (last_c - first_c + 1 !== 16) begin
            bad++;
            $display("FAIL b2b span got=%0d want=16", last_c - first_c + 1);
        end
        total++;
        if (low_cnt !== 8) begin
            bad++;
            $display("FAIL b2b din_rdy_low got=%0d want=8", low_cnt);
        end
    endtask

    task automatic test_k1();
        logic [7:0] m[$];
        bit to;
        do_reset();
        sel = 2;
        for (int w = 0; w < 3; w++) begin
            m.delete();
            m.push_back(8'($urandom));
            src = {src, m};
            add_exp(m);
        end
        run(100, 100, 15, 100, to);
        total++;
        if (to || low_cnt !== 12) begin
            bad++;
            $display("FAIL k1 timing to=%0d low got=%0d want=12", to, low_cnt);
        end
        for (int i = 0; i < 15; i++) begin
            total++;
            if (got(i) !== exp_q[i]) begin
                bad++;
                $display("FAIL k1 beat%0d got=%h want=%h", i, got(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m[$];
        bit to;
        do_reset();
        sel = 0;
        src.push_back(8'($urandom));
        src.push_back(8'($urandom));
        run(100, 100, 2, 50, to);
        total++;
        if (to || s_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy to=%0d busy got=%b want=1", to, s_busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({s_rdy, s_vld, s_busy, s_beat} !== 14'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h want=0", {s_rdy, s_vld, s_busy, s_beat});
        end
        @(negedge clk);
        rstn = 1'b1;
        cap.delete();
        src.delete();
        exp_q.delete();
        for (int b = 0; b < 4; b++) m.push_back(8'($urandom));
        src = m;
        add_exp(m);
        run(90, 80, 8, 200, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL mid_after timeout beats=%0d want=8", cap.size());
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (got(i) !== exp_q[i]) begin
                bad++;
                $display("FAIL mid_after beat%0d got=%h want=%h", i, got(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        localparam int NM = 40;
        logic [7:0] m[$];
        logic [31:0] syn;
        logic [7:0] s;
        int errs;
        bit to;
        do_reset();
        sel = 1;
        for (int w = 0; w < NM; w++) begin
            m.delete();
            for (int b = 0; b < 251; b++) m.push_back(8'($urandom));
            src = {src, m};
            add_exp(m);
        end
        run(80, 70, NM * 255, 60000, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL rand timeout beats=%0d want=%0d", cap.size(), NM * 255);
        end
        for (int w = 0; w < NM; w++) begin
            errs = 0;
            for (int k = 0; k < 255; k++) if (got(w*255+k) !== exp_q[w*255+k]) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL rand cw%0d model mismatched_beats got=%0d want=0", w, errs);
            end
            for (int j = 0; j < 4; j++) begin
                s = 8'h00;
                for (int k = 0; k < 255; k++) s = gmul(s, apow(j)) ^ got(w*255+k)[7:0];
                syn[31-8*j -: 8] = s;
            end
            total++;
            if (syn !== 32'h0) begin
                bad++;
                $display("FAIL rand cw%0d syndromes got=%h want=0", w, syn);
            end
        end
        total++;
        if (stall_err !== 0) begin
            bad++;
            $display("FAIL rand stall_stability changes got=%0d want=0 (stalls=%0d)", stall_err, stall_cnt);
        end
    endtask

    initial begin
        build_g();
        test_reset();
        test_known();
        test_back_to_back();
        test_k1();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
